// File: rtl/hs_pkg.sv
// Shared definitions for the handshake FIFO: default payload width and a
// constant-evaluable ceil(log2) used to size pointers and the level counter.
package hs_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    // ceil(log2(value)); value >= 2 gives at least 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem != 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : hs_pkg

// File: rtl/hs_fifo_mem.sv
// Storage for the handshake FIFO: synchronous write, registered read.
// The read register clears on reset so dout starts at zero; the array
// itself is not reset.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when no read is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : hs_fifo_mem

// File: rtl/handshake_fifo.sv
// Req/ack pulse-protocol FIFO: consumer toward upstream (req_l/ack_l),
// producer toward downstream (req_r/ack_r). One upstream request is
// outstanding at a time, so writes can never overflow; no write-to-read
// bypass. Optional macro HANDSHAKE_FIFO_CHECK_EN enables a sticky flag for
// acks that arrive without an outstanding request.
module handshake_fifo
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    req_l,
    input  logic                    ack_l,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    req_r,
    output logic                    ack_r,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [clog2(DEPTH):0]   level,
    output logic                    proto_err
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rst_done;
    logic             wr_en;
    logic             rd_en;

    // Transfer strobes: write on an ack to our request, read when a new
    // downstream request finds data stored before this edge
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_en = ack_l & req_l;
        rd_en = req_r & ~ack_r & (level != '0);
    end

    // Pointers, level, handshake outputs; rst_done delays the first
    // request to the second edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done <= 1'b0;
            req_l    <= 1'b0;
            ack_r    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            rst_done <= 1'b1;

            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                req_l  <= 1'b0;
            end else if (!req_l && !ack_l && rst_done && (level < FULL)) begin
                req_l <= 1'b1;
            end

            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ack_r <= rd_en;

            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef HANDSHAKE_FIFO_CHECK_EN
    logic spurious;

    // An ack with no outstanding request; its data is dropped
    always_comb begin
        spurious = 1'b0;
        spurious = ack_l & ~req_l;
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (spurious) begin
            proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

    hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule : handshake_fifo

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo (DATA_WIDTH=32, DEPTH=4): reset,
// fill/drain/simultaneous table, spurious ack, streaming, reset mid-stream.
// Expects proto_err behaviour according to HANDSHAKE_FIFO_CHECK_EN.
module tb_handshake_fifo;

    logic        clk;
    logic        rst;
    logic        req_l;
    logic        ack_l;
    logic [31:0] din;
    logic        req_r;
    logic        ack_r;
    logic [31:0] dout;
    logic [2:0]  level;
    logic        proto_err;

`ifdef HANDSHAKE_FIFO_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    typedef struct {
        logic        ack_l;
        logic [31:0] din;
        logic        req_r;
        logic        req_l;
        logic        ack_r;
        logic [31:0] dout;
        logic [2:0]  level;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   tx, rx, cyc, bad_data, bad_level, n;

    handshake_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_l     (req_l),
        .ack_l     (ack_l),
        .din       (din),
        .req_r     (req_r),
        .ack_r     (ack_r),
        .dout      (dout),
        .level     (level),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic a, input logic [31:0] d, input logic rr,
                       input logic e_rl, input logic e_ar, input logic [31:0] e_do,
                       input logic [2:0] e_lv);
        vec_t v;
        v.ack_l = a;  v.din = d;   v.req_r = rr;
        v.req_l = e_rl; v.ack_r = e_ar; v.dout = e_do; v.level = e_lv;
        vq.push_back(v);
    endtask

    // Wait (bounded) for an upstream request, then ack it with one word
    task automatic push(input logic [31:0] w);
        int k;
        k = 0;
        while (req_l !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("push_req", 32'(req_l), 32'd1);
        ack_l = 1'b1;
        din   = w;
        step();
        ack_l = 1'b0;
        din   = 32'd0;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        step();
        check("rel_edge1_req_l", 32'(req_l), 32'd0);
        step();
        check("rel_edge2_req_l", 32'(req_l), 32'd1);
    endtask

    initial begin
        rst   = 1'b0;
        ack_l = 1'b0;
        din   = 32'd0;
        req_r = 1'b0;

        // Fill, full hold, drain
        add(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0,  3'd1);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  3'd1);
        add(1'b1, 32'd11, 1'b0, 1'b0, 1'b0, 32'd0,  3'd2);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  3'd2);
        add(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 32'd0,  3'd3);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  3'd3);
        add(1'b1, 32'd13, 1'b0, 1'b0, 1'b0, 32'd0,  3'd4);
        add(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  3'd4);
        add(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  3'd4);
        add(1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd10, 3'd3);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd10, 3'd3);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd11, 3'd2);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd11, 3'd2);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd12, 3'd1);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd12, 3'd1);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd13, 3'd0);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd13, 3'd0);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd13, 3'd0);
        // Level 2 then simultaneous write and read
        add(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 32'd13, 3'd1);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd13, 3'd1);
        add(1'b1, 32'd21, 1'b0, 1'b0, 1'b0, 32'd13, 3'd2);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd13, 3'd2);
        add(1'b1, 32'd22, 1'b1, 1'b0, 1'b1, 32'd20, 3'd2);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd20, 3'd2);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd21, 3'd1);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd21, 3'd1);
        add(1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd22, 3'd0);
        add(1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd22, 3'd0);

        // Reset state
        step();
        step();
        check("rst_req_l",     32'(req_l),     32'd0);
        check("rst_ack_r",     32'(ack_r),     32'd0);
        check("rst_dout",      dout,           32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        release_reset();

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            ack_l = vq[i].ack_l;
            din   = vq[i].din;
            req_r = vq[i].req_r;
            step();
            check($sformatf("vec%0d_req_l", i), 32'(req_l), 32'(vq[i].req_l));
            check($sformatf("vec%0d_ack_r", i), 32'(ack_r), 32'(vq[i].ack_r));
            check($sformatf("vec%0d_dout", i),  dout,       vq[i].dout);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vq[i].level));
        end

        // Spurious ack while no request is outstanding
        ack_l = 1'b1; din = 32'd30; req_r = 1'b0;
        step();
        check("sp_write_level", 32'(level), 32'd1);
        check("sp_write_req_l", 32'(req_l), 32'd0);
        ack_l = 1'b1; din = 32'h0000_DEAD;
        step();
        check("sp_level",     32'(level),     32'd1);
        check("sp_req_l",     32'(req_l),     32'd0);
        check("sp_proto_err", 32'(proto_err), 32'(EXP_CHK));
        ack_l = 1'b0; din = 32'd0;
        step();
        check("sp_req_l_after", 32'(req_l),     32'd1);
        check("sp_sticky1",     32'(proto_err), 32'(EXP_CHK));
        req_r = 1'b1;
        step();
        check("sp_drain_ack",   32'(ack_r),  32'd1);
        check("sp_drain_dout",  dout,        32'd30);
        check("sp_drain_level", 32'(level),  32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("sp_no_dead_ack",  32'(ack_r), 32'd0);
            check("sp_no_dead_dout", dout,       32'd30);
        end
        check("sp_sticky2", 32'(proto_err), 32'(EXP_CHK));
        req_r = 1'b0;

        // Streaming 0..4999 with an always-ready producer and consumer
        tx = 0; rx = 0; cyc = 0; bad_data = 0; bad_level = 0;
        ack_l = 1'b0;
        req_r = 1'b1;
        while (rx < 5000 && cyc < 30000) begin
            step();
            cyc++;
            if (ack_r === 1'b1) begin
                if (dout !== 32'(rx)) bad_data++;
                rx++;
            end
            if (level > 3'd4) bad_level++;
            if (req_l === 1'b1 && tx < 5000) begin
                ack_l = 1'b1;
                din   = 32'(tx);
                tx++;
            end else begin
                ack_l = 1'b0;
                din   = 32'd0;
            end
        end
        ack_l = 1'b0;
        req_r = 1'b0;
        check("stream_rx_count",  32'(rx),        32'd5000);
        check("stream_bad_data",  32'(bad_data),  32'd0);
        check("stream_bad_level", 32'(bad_level), 32'd0);
        step();

        // Reset while ack_r is high at level 3
        push(32'd40);
        push(32'd41);
        push(32'd42);
        push(32'd43);
        check("mid_full_level", 32'(level), 32'd4);
        req_r = 1'b1;
        step();
        check("mid_ack_r", 32'(ack_r), 32'd1);
        check("mid_dout",  dout,       32'd40);
        check("mid_level", 32'(level), 32'd3);
        req_r = 1'b0;
        rst   = 1'b0;
        #1;
        check("mid_rst_ack_r", 32'(ack_r),     32'd0);
        check("mid_rst_req_l", 32'(req_l),     32'd0);
        check("mid_rst_level", 32'(level),     32'd0);
        check("mid_rst_dout",  dout,           32'd0);
        check("mid_rst_perr",  32'(proto_err), 32'd0);
        ack_l = 1'b1; din = 32'h77;
        step();
        step();
        ack_l = 1'b0; din = 32'd0;
        release_reset();
        check("post_rst_level", 32'(level), 32'd0);
        push(32'd50);
        req_r = 1'b1;
        n = 0;
        while (ack_r !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("post_rst_ack",   32'(ack_r), 32'd1);
        check("post_rst_first", dout,       32'd50);
        req_r = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_handshake_fifo
